usb_ep_ctrl: RTL

- Endpoint controller between the usb transaction interface and up to NUM_EP per-endpoint packet buffers.
- Latches the active endpoint and keeps the per-endpoint IN/OUT data toggles and stall bits.
- Selects the handshake the core returns.
- Routes OUT bytes to the addressed buffer, muxes IN bytes from it, and reports packet completion with length.

---
 rtl/usb_ep_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_ep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_ctrl
// Brief    : USB endpoint controller. Tracks per-endpoint toggles and stall
//            bits, picks the handshake, and routes OUT/IN bytes to the buffers.
// Revision : 1.0
// ============================================================================
module usb_ep_ctrl #(
    parameter int          NUM_EP   = 4,
    parameter int          MAX_PKT  = 64,
    parameter logic [15:0] ISO_MASK = 16'h0000
) (
    input  logic                  clk_48,
    input  logic                  rst,
    input  logic                  transaction_active,
    input  logic [3:0]            endpoint,
    input  logic                  direction_in,
    input  logic                  setup,
    input  logic                  success,
    input  logic                  data_strobe,
    input  logic [7:0]            data_out,
    output logic                  data_toggle,
    output logic [1:0]            handshake,
    output logic [7:0]            data_in,
    output logic                  data_in_valid,
    input  logic [NUM_EP-1:0]     ep_enable,
    input  logic [NUM_EP-1:0]     ep_stall_set,
    input  logic [NUM_EP-1:0]     ep_stall_clr,
    output logic [NUM_EP-1:0]     ep_stall,
    input  logic [NUM_EP-1:0]     ep_out_ready,
    output logic [NUM_EP-1:0]     ep_out_wr,
    output logic [7:0]            ep_out_data,
    output logic [NUM_EP-1:0]     ep_out_done,
    output logic                  ep_out_setup,
    output logic [6:0]            ep_out_len,
    input  logic [NUM_EP-1:0]     ep_in_ready,
    input  logic [8*NUM_EP-1:0]   ep_in_data,
    input  logic [NUM_EP-1:0]     ep_in_valid,
    output logic [NUM_EP-1:0]     ep_in_rd,
    output logic [NUM_EP-1:0]     ep_in_done
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_ACTIVE   = 1'b1;

    localparam logic [1:0] c_HS_ACK   = 2'b00;
    localparam logic [1:0] c_HS_NONE  = 2'b01;
    localparam logic [1:0] c_HS_NAK   = 2'b10;
    localparam logic [1:0] c_HS_STALL = 2'b11;

    localparam logic [6:0] c_CNT_MAX   = 7'(MAX_PKT);
    localparam logic [6:0] c_CNT_LIMIT = 7'(MAX_PKT + 1);

    logic [0:0]        r_state;
    logic [3:0]        r_ep;
    logic              r_dir;
    logic              r_stp;
    logic              r_out_rdy;
    logic              r_in_rdy;
    logic [6:0]        r_cnt;
    logic [NUM_EP-1:0] r_out_done;
    logic [NUM_EP-1:0] r_in_done;
    logic              r_out_setup;
    logic [6:0]        r_out_len;

    logic [NUM_EP-1:0] w_stall_v;
    logic [NUM_EP-1:0] w_tin_v;
    logic [NUM_EP-1:0] w_tout_v;
    logic [NUM_EP-1:0] w_oh;

    // 16-entry views so any 4-bit endpoint index is safe; unimplemented
    // entries read as disabled, which makes them stall.
    logic [15:0]       w_en_x;
    logic [15:0]       w_ordy_x;
    logic [15:0]       w_irdy_x;
    logic [15:0]       w_ival_x;
    logic [15:0]       w_stall_x;
    logic [15:0]       w_tin_x;
    logic [15:0]       w_tout_x;
    logic [15:0][7:0]  w_idata_x;

    logic              w_active;
    logic              w_iso;
    logic              w_ovf;
    logic [1:0]        w_hs;
    logic              w_tog;
    logic              w_byte;
    logic              w_wr;
    logic              w_rd;
    logic              w_success;
    logic              w_accept;
    logic              w_done;
    logic              w_flip;
    logic              w_setup_done;
    logic              w_tuple_chg;
    logic              w_latch;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pad
            if (gi < NUM_EP) begin : g_impl
                assign w_en_x[gi]    = ep_enable[gi];
                assign w_ordy_x[gi]  = ep_out_ready[gi];
                assign w_irdy_x[gi]  = ep_in_ready[gi];
                assign w_ival_x[gi]  = ep_in_valid[gi];
                assign w_stall_x[gi] = w_stall_v[gi];
                assign w_tin_x[gi]   = w_tin_v[gi];
                assign w_tout_x[gi]  = w_tout_v[gi];
                assign w_idata_x[gi] = ep_in_data[8*gi +: 8];
            end else begin : g_unimpl
                assign w_en_x[gi]    = 1'b0;
                assign w_ordy_x[gi]  = 1'b0;
                assign w_irdy_x[gi]  = 1'b0;
                assign w_ival_x[gi]  = 1'b0;
                assign w_stall_x[gi] = 1'b0;
                assign w_tin_x[gi]   = 1'b0;
                assign w_tout_x[gi]  = 1'b0;
                assign w_idata_x[gi] = 8'h00;
            end
        end
    endgenerate

    assign w_active    = (r_state == c_ACTIVE);
    assign w_iso       = ISO_MASK[r_ep];
    assign w_ovf       = (r_cnt == c_CNT_LIMIT);
    assign w_tuple_chg = ({endpoint, direction_in, setup} != {r_ep, r_dir, r_stp});

    always_comb begin
        w_hs = c_HS_STALL;
        if (w_active) begin
            if (!w_en_x[r_ep]) begin
                w_hs = c_HS_STALL;
            end else if (r_stp) begin
                w_hs = c_HS_ACK;
            end else if (w_stall_x[r_ep]) begin
                w_hs = c_HS_STALL;
            end else if (w_iso) begin
                w_hs = c_HS_NONE;
            end else if (!r_dir && (!r_out_rdy || w_ovf)) begin
                w_hs = c_HS_NAK;
            end else if (r_dir && !r_in_rdy) begin
                w_hs = c_HS_NAK;
            end else begin
                w_hs = c_HS_ACK;
            end
        end
    end

    always_comb begin
        w_tog = 1'b0;
        if (w_active && !r_stp && !w_iso) begin
            w_tog = r_dir ? w_tin_x[r_ep] : w_tout_x[r_ep];
        end
    end

    // A SETUP stays acked past overflow, so the count limit gates writes too.
    assign w_byte       = w_active && data_strobe && !r_dir && (w_hs == c_HS_ACK);
    assign w_wr         = w_byte && (r_cnt < c_CNT_MAX);
    assign w_rd         = w_active && data_strobe && r_dir;
    assign w_success    = w_active && success;
    assign w_accept     = (w_hs == c_HS_ACK) || (w_hs == c_HS_NONE);
    assign w_done       = w_success && w_accept;
    assign w_flip       = w_success && (w_hs == c_HS_ACK) && !r_stp && !w_iso;
    assign w_setup_done = w_done && r_stp;
    assign w_latch      = transaction_active &&
                          (!w_active || (!success && w_tuple_chg));

    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ep        <= 4'd0;
            r_dir       <= 1'b0;
            r_stp       <= 1'b0;
            r_out_rdy   <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_cnt       <= 7'd0;
            r_out_done  <= '0;
            r_in_done   <= '0;
            r_out_setup <= 1'b0;
            r_out_len   <= 7'd0;
        end else begin
            r_out_done <= '0;
            r_in_done  <= '0;
            if (w_latch) begin
                r_ep      <= endpoint;
                r_dir     <= direction_in;
                r_stp     <= setup;
                r_out_rdy <= w_ordy_x[endpoint];
                r_in_rdy  <= w_irdy_x[endpoint];
                r_cnt     <= 7'd0;
                r_state   <= c_ACTIVE;
            end else if (w_active) begin
                if (success) begin
                    if (w_accept) begin
                        if (r_dir) begin
                            r_in_done <= w_oh;
                        end else begin
                            r_out_done  <= w_oh;
                            r_out_len   <= r_cnt;
                            r_out_setup <= r_stp;
                        end
                    end
                    r_state <= c_IDLE;
                end else if (!transaction_active) begin
                    r_state <= c_IDLE;
                end else if (w_byte && !w_ovf) begin
                    r_cnt <= r_cnt + 7'd1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_EP; gi++) begin : g_ep
            logic r_stall_b;
            logic r_tin_b;
            logic r_tout_b;

            assign w_oh[gi]      = (r_ep == 4'(gi));
            assign w_stall_v[gi] = r_stall_b;
            assign w_tin_v[gi]   = r_tin_b;
            assign w_tout_v[gi]  = r_tout_b;

            // Set wins over both clear sources; a disabled endpoint pins
            // both toggles low regardless of any success update.
            always_ff @(posedge clk_48 or posedge rst) begin
                if (rst) begin
                    r_stall_b <= 1'b0;
                    r_tin_b   <= 1'b0;
                    r_tout_b  <= 1'b0;
                end else begin
                    if (ep_stall_set[gi]) begin
                        r_stall_b <= 1'b1;
                    end else if (ep_stall_clr[gi] || (w_oh[gi] && w_setup_done)) begin
                        r_stall_b <= 1'b0;
                    end

                    if (!ep_enable[gi]) begin
                        r_tin_b  <= 1'b0;
                        r_tout_b <= 1'b0;
                    end else if (w_oh[gi] && w_setup_done) begin
                        r_tin_b  <= 1'b1;
                        r_tout_b <= 1'b1;
                    end else if (w_oh[gi] && w_flip) begin
                        if (r_dir) begin
                            r_tin_b <= ~r_tin_b;
                        end else begin
                            r_tout_b <= ~r_tout_b;
                        end
                    end
                end
            end
        end
    endgenerate

    assign handshake     = w_hs;
    assign data_toggle   = w_tog;
    assign data_in       = (w_active && r_dir) ? w_idata_x[r_ep] : 8'h00;
    assign data_in_valid = w_active && r_dir && w_ival_x[r_ep];
    assign ep_stall      = w_stall_v;
    assign ep_out_wr     = w_wr ? w_oh : '0;
    assign ep_out_data   = data_out;
    assign ep_out_done   = r_out_done;
    assign ep_out_setup  = r_out_setup;
    assign ep_out_len    = r_out_len;
    assign ep_in_rd      = w_rd ? w_oh : '0;
    assign ep_in_done    = r_in_done;

endmodule
`default_nettype wire
